// File: rtl/stage_execute_mc_if.sv
// Execute-stage bus: everything the stage exchanges with the decode/register
// read stage above it and the memory stage below it. clk and rst are not in
// the bundle.
//   master : the environment side (drives instruction fields, reads results)
//   slave  : the execute stage itself
// Upstream/instruction fields : pc, dest, aluop, reg_a, reg_b, reg_m,
//                               is_mem_in, mem_write_in, is_jump, stall_in
// Stall / forwarding          : stall, fwd_valid, fwd_addr, fwd_val
// Fetch redirect              : jump, jump_addr
// Memory-stage outputs        : out_addr, out_val, is_mem, mem_addr, mem_val,
//                               mem_write
// Status                      : busy
interface stage_execute_mc_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 4
);
  logic [XLEN-1:0]  pc;
  logic             stall_in;
  logic             stall;
  logic [RADDR-1:0] dest;
  logic [3:0]       aluop;
  logic [XLEN-1:0]  reg_a;
  logic [XLEN-1:0]  reg_b;
  logic [XLEN-1:0]  reg_m;
  logic             is_mem_in;
  logic             mem_write_in;
  logic             is_jump;
  logic             fwd_valid;
  logic [RADDR-1:0] fwd_addr;
  logic [XLEN-1:0]  fwd_val;
  logic             jump;
  logic [XLEN-1:0]  jump_addr;
  logic [RADDR-1:0] out_addr;
  logic [XLEN-1:0]  out_val;
  logic             is_mem;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_val;
  logic             mem_write;
  logic             busy;

  modport master (
    output pc, stall_in, dest, aluop, reg_a, reg_b, reg_m,
           is_mem_in, mem_write_in, is_jump,
    input  stall, fwd_valid, fwd_addr, fwd_val, jump, jump_addr,
           out_addr, out_val, is_mem, mem_addr, mem_val, mem_write, busy
  );

  modport slave (
    input  pc, stall_in, dest, aluop, reg_a, reg_b, reg_m,
           is_mem_in, mem_write_in, is_jump,
    output stall, fwd_valid, fwd_addr, fwd_val, jump, jump_addr,
           out_addr, out_val, is_mem, mem_addr, mem_val, mem_write, busy
  );
endinterface

// File: rtl/stage_execute_mc.sv
// Execute stage with an iterative multiply/divide unit.
// Single-cycle ops (add/sub/logic/shifts/slt/sltu, jumps, memory address
// generation) complete in the cycle they arrive. mul/mulhu/divu/remu run one
// bit per cycle in a shared 2*XLEN accumulator; while they run, the stage
// stalls upstream and sends bubbles to the memory stage.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (aborts any multi-cycle op)
//   bus  : stage_execute_mc_if.slave, see the interface for the signal list
module stage_execute_mc #(
  parameter int XLEN  = 32,
  parameter int RADDR = 4
) (
  input logic               clk,
  input logic               rst,
  stage_execute_mc_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [2*XLEN-1:0] acc_reg, acc_next;   // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]   opb_reg, opb_next;   // multiplicand / divisor
  logic [1:0]        op_reg, op_next;     // aluop[1:0]: 0 mul, 1 mulhu, 2 divu, 3 remu

  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  addr_sum;
  logic [SHW-1:0]   shamt;
  logic             mc;
  logic [XLEN:0]    mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]  mc_result;
  logic             stall_c;
  logic             fwd_valid_c;
  logic [XLEN-1:0]  fwd_val_c;

  logic [RADDR-1:0] out_addr_reg;
  logic [XLEN-1:0]  out_val_reg;
  logic             is_mem_reg;

  assign addr_sum = bus.reg_a + bus.reg_b;
  assign shamt    = bus.reg_b[SHW-1:0];
  assign mc       = (bus.aluop[3:2] == 2'b10) && !bus.is_jump && !bus.is_mem_in;

  // Single-cycle result. Codes 8..B only reach here when they are not
  // multi-cycle (jump or memory op), so they yield 0 like E/F.
  always_comb begin
    alu_result = '0;
    case (bus.aluop)
      4'h0: alu_result = bus.reg_a + bus.reg_b;
      4'h1: alu_result = bus.reg_a - bus.reg_b;
      4'h2: alu_result = bus.reg_a & bus.reg_b;
      4'h3: alu_result = bus.reg_a | bus.reg_b;
      4'h4: alu_result = bus.reg_a ^ bus.reg_b;
      4'h5: alu_result = bus.reg_a << shamt;
      4'h6: alu_result = bus.reg_a >> shamt;
      4'h7: alu_result = $unsigned($signed(bus.reg_a) >>> shamt);
      4'hC: alu_result = {{(XLEN-1){1'b0}}, ($signed(bus.reg_a) < $signed(bus.reg_b))};
      4'hD: alu_result = {{(XLEN-1){1'b0}}, (bus.reg_a < bus.reg_b)};
      default: alu_result = '0;
    endcase
    if (bus.is_jump)
      alu_result = bus.pc + XLEN'(4);
  end

  // Shift-add multiply step: multiplier sits in lo and is consumed from bit 0,
  // partial product grows in hi; the carry of the add shifts back into hi.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : {(XLEN+1){1'b0}});
    mul_step = {mul_sum, acc_reg[XLEN-1:1]};
  end

  // Restoring divide step: shift {rem, dividend} left, try subtracting the
  // divisor from the remainder, keep it if non-negative. A zero divisor always
  // "succeeds", which yields quotient = all ones and remainder = dividend.
  always_comb begin
    div_shift = acc_reg[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_reg};
    if (div_diff[XLEN])
      div_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
    else
      div_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
  end

  // mulhu and remu live in the high half, mul and divu in the low half.
  assign mc_result = op_reg[0] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    acc_next    = acc_reg;
    opb_next    = opb_reg;
    op_next     = op_reg;
    stall_c     = bus.stall_in;
    fwd_valid_c = !bus.is_mem_in;
    fwd_val_c   = alu_result;
    case (state_reg)
      IDLE: begin
        if (mc) begin
          state_next  = BUSY;
          count_next  = CW'(XLEN - 1);
          acc_next    = {{XLEN{1'b0}}, bus.reg_a};
          opb_next    = bus.reg_b;
          op_next     = bus.aluop[1:0];
          stall_c     = 1'b1;
          fwd_valid_c = 1'b0;
        end
      end
      BUSY: begin
        stall_c     = 1'b1;
        fwd_valid_c = 1'b0;
        acc_next    = op_reg[1] ? div_step : mul_step;
        count_next  = count_reg - CW'(1);
        if (count_reg == '0)
          state_next = DONE;
      end
      DONE: begin
        fwd_val_c   = mc_result;
        fwd_valid_c = 1'b1;
        stall_c     = bus.stall_in;
        if (!bus.stall_in)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      acc_reg   <= '0;
      opb_reg   <= '0;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      acc_reg   <= acc_next;
      opb_reg   <= opb_next;
      op_reg    <= op_next;
    end
  end

  // Pipeline register to the memory stage: advance when not stalled, insert a
  // bubble when the stall is our own, hold when downstream is stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr_reg <= '0;
      out_val_reg  <= '0;
      is_mem_reg   <= 1'b0;
    end else if (!stall_c) begin
      out_addr_reg <= bus.dest;
      out_val_reg  <= fwd_val_c;
      is_mem_reg   <= bus.is_mem_in;
    end else if (!bus.stall_in) begin
      out_addr_reg <= '0;
      out_val_reg  <= '0;
      is_mem_reg   <= 1'b0;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_valid = fwd_valid_c;
  assign bus.fwd_addr  = bus.dest;
  assign bus.fwd_val   = fwd_val_c;
  assign bus.jump      = bus.is_jump;
  assign bus.jump_addr = addr_sum;
  assign bus.mem_addr  = addr_sum;
  assign bus.mem_val   = bus.reg_m;
  assign bus.mem_write = bus.mem_write_in;
  assign bus.out_addr  = out_addr_reg;
  assign bus.out_val   = out_val_reg;
  assign bus.is_mem    = is_mem_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: doc/stage_execute_mc.md
Name: stage_execute_mc

Overview:
- Parametrised execute stage adding an iterative multiply/divide unit and set-less-than compares to the single-cycle ALU/jump/memory-address path.
- Sits between the decode/register-read stage and the memory stage.
- Multi-cycle ops hold the pipeline through the shared stall chain and emit bubbles downstream until their result retires.

Parameters:
XLEN, 32, datapath width in bits (power of two, >= 8)
RADDR, 4, register address width; address 0 denotes "no writeback"/bubble

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pc  in  XLEN  PC of the instruction in this stage
stall_in  in  1  stall request from downstream
stall  out  1  stall to upstream
dest  in  RADDR  destination register
aluop  in  4  operation select
reg_a  in  XLEN  operand A
reg_b  in  XLEN  operand B
reg_m  in  XLEN  store data
is_mem_in  in  1  instruction is load/store
mem_write_in  in  1  instruction is a store
is_jump  in  1  instruction is a jump
fwd_valid  out  1  fwd_val is usable this cycle
fwd_addr  out  RADDR  forwarded destination
fwd_val  out  XLEN  forwarded result
jump  out  1  redirect fetch
jump_addr  out  XLEN  jump target
out_addr  out  RADDR  registered destination to memory stage
out_val  out  XLEN  registered result
is_mem  out  1  registered memory-op flag
mem_addr  out  XLEN  reg_a+reg_b
mem_val  out  XLEN  reg_m pass-through
mem_write  out  1  mem_write_in pass-through
busy  out  1  FSM not IDLE

Behaviour:
- aluop: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 mul (low XLEN), 9 mulhu (high XLEN, unsigned), A divu, B remu, C slt (signed, 0/1), D sltu, E/F yield 0.
- Shifts use only the low log2(XLEN) bits of B.
- is_jump forces result = pc + 4 (single-cycle); jump = is_jump, jump_addr = mem_addr = reg_a + reg_b (mod 2^XLEN).
- Multi-cycle op (mc) = aluop 8..B with is_jump = 0 and is_mem_in = 0.
- FSM states IDLE, BUSY, DONE; reset -> IDLE.
- IDLE, mc present:
  - latch operands, counter = XLEN - 1, go BUSY;
  - stall = 1; fwd_valid = 0.
- IDLE, no mc: single-cycle path, stall = stall_in, fwd_valid = ~is_mem_in.
- BUSY:
  - one multiply bit (shift-add, 2*XLEN accumulator) or one restoring-divide step per cycle;
  - counter decrements; after XLEN BUSY cycles go DONE;
  - stall = 1; fwd_valid = 0.
- DONE:
  - fwd_val = mc result, fwd_valid = 1, stall = stall_in;
  - if ~stall_in: register result, go IDLE; else hold DONE.
- Upstream holds all inputs while stall = 1. Operands are sampled only at IDLE -> BUSY.
- Latency of a mc op with stall_in = 0: stall high XLEN + 1 cycles; out_* updated at the clock edge closing DONE (XLEN + 2 cycles after acceptance).
- Divide by zero: divu = all ones, remu = reg_a. No trap.
- Output register update per clock edge, first match wins:
  - rst: out_addr = 0, out_val = 0, is_mem = 0.
  - ~stall: out_addr = dest, out_val = fwd_val, is_mem = is_mem_in.
  - stall & ~stall_in (self-generated): bubble, out_addr = 0, out_val = 0, is_mem = 0.
  - stall_in: hold.
- rst during BUSY/DONE: abort, IDLE, counter/accumulators cleared. No partial result is ever emitted.
- mem_val, mem_write, fwd_addr = dest are combinational and always driven.
- busy = (state != IDLE).

Test Plan:
- XLEN=32, aluop 0, a=5, b=7, dest=3, stall_in=0 -> fwd_val=12, fwd_valid=1, next edge out_addr=3, out_val=12, stall never high.
- aluop 8, a=7, b=6, dest=2 -> stall high exactly 33 cycles; out_addr=0 bubbles during that time; then out_addr=2, out_val=42. Repeat with aluop 9, a=b=0xFFFFFFFF -> out_val=0xFFFFFFFE.
- aluop A, a=100, b=0 -> out_val=0xFFFFFFFF. aluop B, a=100, b=7 -> out_val=2. aluop C, a=0xFFFFFFFF, b=1 -> 1; aluop D, same operands -> 0.
- mc op reaching DONE with stall_in=1 for 5 cycles -> FSM holds DONE, out_* unchanged, fwd_valid=1; stall_in drops -> result retires, busy=0 next cycle.
- rst asserted on 10th BUSY cycle of a divu -> next edge busy=0, out_addr=0, is_mem=0; following add instruction retires normally.
- is_jump=1, pc=0x100, a=0x200, b=0x10 -> jump=1, jump_addr=0x210, out_val=0x104. Separately: aluop 7, a=0x80000000, b=33 -> out_val=0xC0000000.
